// File: rtl/float_to_linear.sv
// Sequential decoder from the 8-bit S/E/F float code to a DW-bit two's-complement linear value.
// The significand is shifted left one bit per cycle for E cycles, then the sign is applied once.
module float_to_linear #(
    parameter int DW = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 S,
    input  logic [2:0]           E,
    input  logic [3:0]           F,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] D,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        SIGN  = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [10:0] mag;
    logic [2:0]  cnt;
    logic        sign;

    // Magnitude never exceeds 1920, so negation of the zero-extended value cannot overflow.
    function automatic logic signed [DW-1:0] apply_sign(input logic neg, input logic [10:0] m);
        logic signed [DW-1:0] ext;
        ext = signed'({{(DW-11){1'b0}}, m});
        return neg ? -ext : ext;
    endfunction

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = (E != 3'd0) ? SHIFT : SIGN;
            SHIFT:   if (cnt == 3'd1) state_nxt = SIGN;
            SIGN:    state_nxt = OUT;
            OUT:     if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == OUT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            mag   <= '0;
            cnt   <= '0;
            sign  <= 1'b0;
            D     <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign <= S;
                        mag  <= {7'd0, F};
                        cnt  <= E;
                    end
                end
                SHIFT: begin
                    mag <= mag << 1;
                    cnt <= cnt - 3'd1;
                end
                SIGN:    D <= apply_sign(sign, mag);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_float_to_linear.sv
// Directed bench for float_to_linear: reset, latency, arithmetic corners, backpressure, mid-job reset.
module tb_float_to_linear;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        S;
    logic [2:0]  E;
    logic [3:0]  F;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] D;
    logic        busy;

    int checks = 0;
    int errors = 0;

    float_to_linear #(.DW(12)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .S        (S),
        .E        (E),
        .F        (F),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .D        (D),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Presents one code for a single accept edge; returns #1 after that edge.
    task automatic start_job(input logic s, input logic [2:0] e, input logic [3:0] f);
        S = s; E = e; F = f;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Counts edges until out_valid is seen; bounded at 20.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (D !== 12'h000) begin errors++; $display("FAIL reset_D got %h want 000", D); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    endtask

    task automatic test_zero();
        int lat;
        start_job(1'b0, 3'd0, 4'd0);
        wait_valid(lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL zero_latency got %0d want 1", lat); end
        checks++; if (D !== 12'h000) begin errors++; $display("FAIL zero_D got %h want 000", D); end
        handshake();
        start_job(1'b1, 3'd4, 4'd0);
        wait_valid(lat);
        checks++; if (lat !== 5) begin errors++; $display("FAIL negzero_latency got %0d want 5", lat); end
        checks++; if (D !== 12'h000) begin errors++; $display("FAIL negzero_D got %h want 000", D); end
        handshake();
    endtask

    task automatic test_shift();
        int lat;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL shift_in_ready got %b want 1", in_ready); end
        start_job(1'b0, 3'd3, 4'd13);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL shift_busy got %b want 1", busy); end
        wait_valid(lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL shift_latency got %0d want 4", lat); end
        checks++; if (D !== 12'h068) begin errors++; $display("FAIL shift_D got %h want 068", D); end
        handshake();
    endtask

    task automatic test_negative();
        int lat;
        start_job(1'b1, 3'd7, 4'd15);
        wait_valid(lat);
        checks++; if (lat !== 8) begin errors++; $display("FAIL maxneg_latency got %0d want 8", lat); end
        checks++; if (D !== 12'h880) begin errors++; $display("FAIL maxneg_D got %h want 880", D); end
        handshake();
        start_job(1'b1, 3'd2, 4'd5);
        wait_valid(lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL neg20_latency got %0d want 3", lat); end
        checks++; if (D !== 12'hFEC) begin errors++; $display("FAIL neg20_D got %h want fec", D); end
        handshake();
        start_job(1'b0, 3'd7, 4'd15);
        wait_valid(lat);
        checks++; if (D !== 12'h780) begin errors++; $display("FAIL maxpos_D got %h want 780", D); end
        handshake();
    endtask

    task automatic test_backpressure();
        int lat;
        // 9 << 2 = 36; a code sneaking in while busy would change D or latency.
        start_job(1'b0, 3'd2, 4'd9);
        S = 1'b1; E = 3'd0; F = 4'd1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_valid(lat);
        checks++; if (lat + 1 !== 3) begin errors++; $display("FAIL bp_latency got %0d want 3", lat + 1); end
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            F = 4'(i + 3);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid cycle %0d got %b want 1", i, out_valid); end
            checks++; if (D !== 12'h024) begin errors++; $display("FAIL bp_D cycle %0d got %h want 024", i, D); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cycle %0d got %b want 0", i, in_ready); end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_end got %b want 1", out_valid); end
        handshake();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got %b want 1", in_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_release_busy got %b want 0", busy); end
        checks++; if (D !== 12'h024) begin errors++; $display("FAIL bp_idle_D got %h want 024", D); end
        // out_ready in IDLE must not start anything.
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL idle_out_ready got busy=%b valid=%b want 0 0", busy, out_valid); end
    endtask

    task automatic test_reset_mid_shift();
        int lat;
        start_job(1'b0, 3'd6, 4'd15);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b want 1", in_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b want 0", out_valid); end
        checks++; if (D !== 12'h000) begin errors++; $display("FAIL midrst_D got %h want 000", D); end
        start_job(1'b0, 3'd1, 4'd1);
        wait_valid(lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL post_rst_latency got %0d want 2", lat); end
        checks++; if (D !== 12'h002) begin errors++; $display("FAIL post_rst_D got %h want 002", D); end
        handshake();
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        S = 1'b0; E = 3'd0; F = 4'd0;
        @(posedge clk); #1;
        test_reset();
        test_zero();
        test_shift();
        test_negative();
        test_backpressure();
        test_reset_mid_shift();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
